// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver state encoding, default word width and
// the bus mode used by both ends of the link.
package spi_pkg;

    // Word width shared with the master's data_to_send port
    localparam int SPI_DATA_WIDTH = 8;

    // Mode 0: sclk idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small first-word-fall-through FIFO. Pointers carry one extra wrap bit so
// full and empty can be told apart without a separate occupancy counter.
// The output reads as zero while empty so nothing stale leaks downstream.
module spi_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO only lands when a pop frees the slot that cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointer arithmetic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver running entirely in the system clock domain. The SPI
// pins are oversampled through synchronisers, rising sclk is edge-detected,
// and completed MSB-first words are queued in a small FIFO for a
// valid/ready consumer.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  system_clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_active,
    output logic                  overrun,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
    logic                   sclk_s, mosi_s, cs_n_s;
    logic                   sclk_q, sclk_rise;

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]  word_next;
    logic                   push, pop;
    logic                   fifo_full, fifo_empty;
    logic                   overrun_q, overrun_d;
    logic                   frame_error_q, frame_error_d;

    // Synchronisers; cs_n resets high so a reset never looks like a select
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            sclk_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_q      <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;

    // mosi passes through the same depth as sclk, so it lines up with the edge
    assign word_next = {shreg_q[DATA_WIDTH-2:0], mosi_s};
    assign pop       = rx_valid & rx_ready;

    // Frame FSM: deassertion of cs_n takes priority over a coincident sclk edge
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        push          = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_n_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            SHIFT: begin
                if (cs_n_s) begin
                    state_d       = IDLE;
                    frame_error_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    shreg_d = word_next;
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        push      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completed word with nowhere to go is dropped and flagged
    assign overrun_d = push & fifo_full & ~pop;

    // FSM and status registers
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    spi_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (system_clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (word_next),
        .pop_i   (pop),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid     = ~fifo_empty;
    assign frame_active = (state_q == SHIFT);
    assign overrun      = overrun_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed SPI frames, a cycle-level reference model
// of the receiver, and literal expectations on the words that come out.
module tb_spi_slave_rx;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic          system_clock = 1'b0;
    logic          reset_n;
    logic          sclk, mosi, cs_n, rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, frame_active, overrun, frame_error;

    always #5 system_clock = ~system_clock;

    spi_slave_rx #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_n         (cs_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_active (frame_active),
        .overrun      (overrun),
        .frame_error  (frame_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge system_clock) cyc++;

    // ---------------- reference model ----------------
    // Pins are seen SS edges late; each cycle the receiver either waits for a
    // select, collects one bit per rising sclk, or closes the frame.
    int  pipe_sclk[SS], pipe_mosi[SS], pipe_csn[SS];
    int  m_prev_sclk, m_active, m_cnt, m_word, m_ovr, m_ferr;
    int  m_q[$];
    int  s_sclk, s_mosi, s_csn, m_push, m_pop;

    always @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SS; i++) begin
                pipe_sclk[i] = 0; pipe_mosi[i] = 0; pipe_csn[i] = 1;
            end
            m_prev_sclk = 0; m_active = 0; m_cnt = 0; m_word = 0;
            m_ovr = 0; m_ferr = 0;
            m_q.delete();
        end else begin
            s_sclk = pipe_sclk[SS-1];
            s_mosi = pipe_mosi[SS-1];
            s_csn  = pipe_csn[SS-1];
            m_pop  = (m_q.size() != 0 && rx_ready) ? 1 : 0;
            m_push = 0; m_ovr = 0; m_ferr = 0;
            if (m_active == 0) begin
                if (s_csn == 0) begin
                    m_active = 1; m_cnt = 0; m_word = 0;
                end
            end else if (s_csn == 1) begin
                m_active = 0;
                if (m_cnt != 0) m_ferr = 1;
            end else if (s_sclk == 1 && m_prev_sclk == 0) begin
                m_word = (m_word * 2 + s_mosi) % (1 << DW);
                m_cnt++;
                if (m_cnt == DW) begin
                    m_cnt  = 0;
                    m_push = 1;
                end
            end
            if (m_push && m_q.size() == DEPTH && !m_pop) m_ovr = 1;
            else begin
                if (m_pop)  void'(m_q.pop_front());
                if (m_push) m_q.push_back(m_word);
            end
            m_prev_sclk = s_sclk;
            for (int i = SS - 1; i > 0; i--) begin
                pipe_sclk[i] = pipe_sclk[i-1];
                pipe_mosi[i] = pipe_mosi[i-1];
                pipe_csn[i]  = pipe_csn[i-1];
            end
            pipe_sclk[0] = sclk; pipe_mosi[0] = mosi; pipe_csn[0] = cs_n;
        end
    end

    // ---------------- per-cycle compare and event recording ----------------
    int got[$];
    int exp_q[$];
    int ovr_cnt = 0, ferr_cnt = 0, valid_hi = 0;
    int prev_valid = 0, valid_rise_cyc = 0, last_rise_cyc = 0;

    always begin
        @(negedge system_clock);
        #1;
        chk("rx_valid", int'(rx_valid), (m_q.size() != 0) ? 1 : 0);
        chk("rx_data", int'(rx_data), (m_q.size() != 0) ? m_q[0] : 0);
        chk("frame_active", int'(frame_active), m_active);
        chk("overrun", int'(overrun), m_ovr);
        chk("frame_error", int'(frame_error), m_ferr);
        if (rx_valid && rx_ready) got.push_back(int'(rx_data));
        if (overrun) ovr_cnt++;
        if (frame_error) ferr_cnt++;
        if (rx_valid) valid_hi++;
        if (rx_valid && prev_valid == 0) valid_rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic spi_bit(input logic b, input bit pulse_ready);
        mosi = b;
        wait_cyc(4);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        if (pulse_ready) begin
            // land rx_ready on the cycle the final edge reaches the FSM
            wait_cyc(SS);
            rx_ready = 1'b1;
            wait_cyc(1);
            rx_ready = 1'b0;
            wait_cyc(4 - SS - 1);
        end else begin
            wait_cyc(4);
        end
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit pulse_last);
        for (int i = DW - 1; i >= 0; i--) spi_bit(v[i], pulse_last && (i == 0));
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_cyc(4);
    endtask

    task automatic frame_end();
        wait_cyc(4);
        cs_n = 1'b1;
        wait_cyc(6);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        wait_cyc(DEPTH + 3);
        rx_ready = 1'b0;
        wait_cyc(1);
    endtask

    task automatic chk_got(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(name, got[i], exp_q[i]);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rx_valid"}, int'(rx_valid), 0);
        chk({name, "_rx_data"}, int'(rx_data), 0);
        chk({name, "_frame_active"}, int'(frame_active), 0);
        chk({name, "_overrun"}, int'(overrun), 0);
        chk({name, "_frame_error"}, int'(frame_error), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; rx_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(3);

        // Single byte, latency counted with the pin-change cycle as cycle 1
        got.delete(); ovr_cnt = 0; ferr_cnt = 0;
        frame_start();
        send_byte(8'hA5, 1'b0);
        frame_end();
        chk("single_latency", valid_rise_cyc - last_rise_cyc + 1, SS + 2);
        chk("single_rx_valid", int'(rx_valid), 1);
        chk("single_rx_data", int'(rx_data), 8'hA5);
        chk("single_overrun", ovr_cnt, 0);
        chk("single_frame_error", ferr_cnt, 0);
        drain();
        exp_q = '{8'hA5};
        chk_got("single_word");

        // Back-to-back words in one frame with the consumer always ready
        got.delete(); valid_hi = 0;
        rx_ready = 1'b1;
        frame_start();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        frame_end();
        rx_ready = 1'b0;
        exp_q = '{8'h3C, 8'hFF, 8'h00};
        chk_got("b2b_word");
        chk("b2b_valid_cycles", valid_hi, 3);

        // Overrun: five words into a four-deep FIFO with nobody reading
        got.delete(); ovr_cnt = 0;
        frame_start();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        frame_end();
        chk("ovr_pulses", ovr_cnt, 1);
        drain();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_got("ovr_word");

        // Full FIFO with a pop landing on the same cycle as the fifth push
        got.delete(); ovr_cnt = 0;
        frame_start();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h05, 1'b1);
        frame_end();
        chk("fullpop_overrun", ovr_cnt, 0);
        exp_q = '{8'h01};
        chk_got("fullpop_first");
        drain();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_got("fullpop_word");

        // Partial frame followed by a clean byte
        got.delete(); ferr_cnt = 0;
        frame_start();
        spi_bit(1'b1, 1'b0);
        spi_bit(1'b0, 1'b0);
        spi_bit(1'b1, 1'b0);
        frame_end();
        chk("partial_frame_error", ferr_cnt, 1);
        chk("partial_no_push", int'(rx_valid), 0);
        frame_start();
        send_byte(8'h81, 1'b0);
        frame_end();
        drain();
        exp_q = '{8'h81};
        chk_got("partial_next_word");

        // Reset in the middle of a frame with two words buffered
        got.delete(); ferr_cnt = 0;
        frame_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0);
        chk("midrst_buffered", int'(rx_valid), 1);
        wait_cyc(1);
        reset_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #1;
        chk_all_zero("midrst");
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(6);
        chk("midrst_frame_error", ferr_cnt, 0);
        frame_start();
        send_byte(8'h5A, 1'b0);
        frame_end();
        drain();
        exp_q = '{8'h5A};
        chk_got("midrst_word");

        wait_cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
